// File: rtl/ref_mem_pkg.sv
// -----------------------------------------------------------------------------
// ref_mem_pkg
// Shared reference-memory geometry used by the memory controller and the row
// aligner: bank count, pixel width, window depth and shift width, plus the
// packed row/window types and the rotation source-index helper.
// -----------------------------------------------------------------------------
package ref_mem_pkg;

    localparam int unsigned NUM_BANKS = 32;
    localparam int unsigned PIX_W     = 8;
    localparam int unsigned WIN_ROWS  = 4;
    localparam int unsigned SHIFT_W   = 5;

    localparam int unsigned ROW_W  = NUM_BANKS * PIX_W;
    localparam int unsigned WIN_W  = ROW_W * WIN_ROWS;
    localparam int unsigned CNT_W  = 7;
    localparam int unsigned FILL_W = 3;

    // One row of pixels; bank k occupies bits [PIX_W*k +: PIX_W].
    typedef logic [NUM_BANKS-1:0][PIX_W-1:0] row_t;

    // Alignment window; row 0 (oldest) occupies the lowest ROW_W bits.
    typedef row_t [WIN_ROWS-1:0] win_t;

    // Source bank for aligned pixel 'pix'; the SHIFT_W-bit sum wraps mod NUM_BANKS.
    function automatic logic [SHIFT_W-1:0] rot_src(input int unsigned pix,
                                                   input logic [SHIFT_W-1:0] shift);
        return SHIFT_W'(pix) + shift;
    endfunction

endpackage

// File: rtl/ref_rotate.sv
// -----------------------------------------------------------------------------
// ref_rotate
// Combinational circular pixel rotation: aligned pixel i = input pixel
// ((i + shift) mod NUM_BANKS).
// Ports:
//   data      in  ROW_W    bank read data, bank k at [PIX_W*k +: PIX_W]
//   shift     in  SHIFT_W  circular pixel offset
//   rotated_c out ROW_W    rotated row (combinational)
// -----------------------------------------------------------------------------
module ref_rotate
    import ref_mem_pkg::*;
(
    input  logic [ROW_W-1:0]   data,
    input  logic [SHIFT_W-1:0] shift,
    output logic [ROW_W-1:0]   rotated_c
);

    row_t src;
    row_t dst;

    // Pure index remap, one pixel mux per output position.
    always_comb begin
        src = row_t'(data);
        dst = '0;
        for (int unsigned i = 0; i < NUM_BANKS; i++) begin
            dst[i] = src[rot_src(i, shift)];
        end
        rotated_c = dst;
    end

endmodule

// File: rtl/ref_row_aligner.sv
// -----------------------------------------------------------------------------
// ref_row_aligner
// Aligns rows read from the 32-bank reference memory by a circular pixel
// shift and keeps a sliding window of the last WIN_ROWS aligned rows.
// Optional macro: REF_ALIGN_OUT_REG_EN adds an output register stage on
// win_data/win_valid (read-to-valid latency 3 instead of 2).
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   clear        in   synchronous window flush
//   rd_en_n      in   active-low bank read strobe (issued with the address)
//   shift_value  in   circular pixel offset, issued with rd_en_n
//   bank_rdata   in   bank read data, valid one cycle after rd_en_n=0
//   win_data     out  window, row 0 (oldest) at [255:0]
//   win_valid    out  one-cycle pulse: window full, newest row just pushed
//   row_cnt      out  rows pushed since clear/reset, mod 128
// -----------------------------------------------------------------------------
module ref_row_aligner
    import ref_mem_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               rd_en_n,
    input  logic [SHIFT_W-1:0] shift_value,
    input  logic [ROW_W-1:0]   bank_rdata,
    output logic [WIN_W-1:0]   win_data,
    output logic               win_valid,
    output logic [CNT_W-1:0]   row_cnt
);

    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(WIN_ROWS);

    logic                strobe_d;
    logic [SHIFT_W-1:0]  shift_d;
    logic [ROW_W-1:0]    aligned_c;
    win_t                window;
    win_t                window_next_c;
    logic [FILL_W-1:0]   fill;
    logic                full_push;

    // S1: delay strobe and shift so they line up with bank_rdata.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strobe_d <= 1'b0;
            shift_d  <= '0;
        end else if (clear) begin
            strobe_d <= 1'b0;
            shift_d  <= '0;
        end else begin
            strobe_d <= ~rd_en_n;
            shift_d  <= shift_value;
        end
    end

    ref_rotate u_rotate (
        .data      (bank_rdata),
        .shift     (shift_d),
        .rotated_c (aligned_c)
    );

    // Window advanced by one row: older rows slide down, newest enters on top.
    always_comb begin
        window_next_c = window;
        for (int unsigned r = 0; r < WIN_ROWS - 1; r++) begin
            window_next_c[r] = window[r+1];
        end
        window_next_c[WIN_ROWS-1] = row_t'(aligned_c);
    end

    // Window, fill level and row counter; clear wins over a coincident push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            window    <= '0;
            fill      <= '0;
            full_push <= 1'b0;
            row_cnt   <= '0;
        end else if (clear) begin
            window    <= '0;
            fill      <= '0;
            full_push <= 1'b0;
            row_cnt   <= '0;
        end else if (strobe_d) begin
            window    <= window_next_c;
            fill      <= (fill == FILL_FULL) ? FILL_FULL : fill + FILL_W'(1);
            full_push <= (fill >= FILL_FULL - FILL_W'(1));
            row_cnt   <= row_cnt + CNT_W'(1);
        end else begin
            full_push <= 1'b0;
        end
    end

`ifdef REF_ALIGN_OUT_REG_EN
    // Extra retiming stage on the window outputs; flushed by clear as well.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_data  <= '0;
            win_valid <= 1'b0;
        end else if (clear) begin
            win_data  <= '0;
            win_valid <= 1'b0;
        end else begin
            win_data  <= WIN_W'(window);
            win_valid <= full_push;
        end
    end
`else
    assign win_data  = WIN_W'(window);
    assign win_valid = full_push;
`endif

endmodule

// File: doc/ref_row_aligner.md
REF_ROW_ALIGNER -- requirements
Module: ref_row_aligner

Interface
REQ-001 SHALL have port clk, input, 1: system clock; all logic rising-edge.
REQ-002 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-003 SHALL have port clear, input, 1: synchronous window flush, active-high.
REQ-004 SHALL have port rd_en_n, input, 1: active-low bank read strobe, issued with the read address by the memory controller.
REQ-005 SHALL have port shift_value, input, 5: circular pixel offset, issued with rd_en_n.
REQ-006 SHALL have port bank_rdata, input, 256: 32 banks x 8-bit pixel; bank k at bits [8k+7:8k]; valid one cycle after rd_en_n=0.
REQ-007 SHALL have port win_data, output, 1024: 4 aligned rows x 256 bits; row 0 (oldest) at bits [255:0].
REQ-008 SHALL have port win_valid, output, 1: window holds 4 rows, newest pushed this cycle.
REQ-009 SHALL have port row_cnt, output, 7: rows pushed since last clear/reset, wraps 127->0.

Function
REQ-010 SHALL delay rd_en_n (inverted) and shift_value by one cycle (stage S1) to align with bank_rdata.
REQ-011 SHALL rotate in S1: aligned pixel i = bank pixel ((i + shift_d) mod 32), i = 0..31.
REQ-012 SHALL push the aligned row into the window at the end of S1 when the delayed strobe is 1; rows 0..2 take rows 1..3, row 3 takes the new row.
REQ-013 SHALL hold the window unchanged when no push occurs.
REQ-014 SHALL keep a fill counter 0..4, +1 per push, saturating at 4.
REQ-015 SHALL assert win_valid for exactly one cycle after each push that leaves fill = 4; latency rd_en_n=0 to win_valid = 2 cycles.
REQ-016 SHALL accept back-to-back pushes every cycle with no bubbles.
REQ-017 SHALL increment row_cnt once per push, modulo 128.
REQ-018 SHALL, on clear, zero the window, fill counter, row_cnt and win_valid, and discard the S1 strobe; clear takes priority over a simultaneous push.
REQ-019 SHALL accept repeated rows (controller address stall) as ordinary pushes; no deduplication.

Reset
REQ-020 SHALL on rst_n=0 asynchronously zero win_data, win_valid, row_cnt, fill counter, and S1 strobe/shift registers.
REQ-021 SHALL, after reset released mid-stream, ignore bank_rdata until the first rd_en_n=0 sampled after release.

Configuration
REQ-022 SHALL support macro REF_ALIGN_OUT_REG_EN: defined -> extra register on win_data/win_valid, latency 3 cycles, clear also zeroes it; undefined -> latency 2 per REQ-015.

Structure
REQ-023 SHALL take NUM_BANKS=32, PIX_W=8, WIN_ROWS=4, SHIFT_W=5 from shared package ref_mem_pkg, which the memory controller also uses.
REQ-024 SHALL place the rotation in one combinational sub-module ref_rotate (256-bit in, 5-bit shift, 256-bit out).

Verification
REQ-025 SHALL cover: 4 pushes, shift 0, bank k = row*32+k -> win_valid on 4th push +2 cycles; row 0 pixel 0 = 0x00, row 3 pixel 31 = 0x7F.
REQ-026 SHALL cover: shift_value=8, bank k = k -> aligned pixel 0 = 8, pixel 24 = 0 (wrap).
REQ-027 SHALL cover: shift_value changes each cycle 0,8,16,24 -> each row rotated by its own delayed shift, no skew.
REQ-028 SHALL cover: clear asserted with delayed strobe=1 -> row_cnt=0, win_valid=0, window all zero; next 3 pushes give win_valid=0.
REQ-029 SHALL cover: 130 continuous pushes -> row_cnt = 2 after wrap, win_valid high from push 4 onward each cycle.
REQ-030 SHALL cover: rst_n pulsed mid-stream -> all outputs 0 immediately; with REF_ALIGN_OUT_REG_EN defined, first win_valid 3 cycles after 4th strobe.
